// File: rtl/decade_chain_pkg.sv
// ============================================================================
// Module   : decade_chain_pkg
// Brief    : Shared types and constants for the decade counter chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decade_chain_pkg;

    localparam int              BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
        return (d >= BCD_MAX) ? '0 : d + 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decade_chain_ctrl_bcd_digit.sv
// ============================================================================
// Module   : bcd_digit
// Brief    : One mod-10 counter digit with parallel load and terminal count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
    import decade_chain_pkg::*;
(
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             LD,
    input  logic [BCD_W-1:0] LD_VAL,
    output logic [BCD_W-1:0] Q,
    output logic             TC
);

    logic [BCD_W-1:0] r_q;

    // Out-of-range presets collapse to 0 so the digit never leaves 0..9.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_q <= '0;
        end else if (LD) begin
            r_q <= (LD_VAL > BCD_MAX) ? '0 : LD_VAL;
        end else if (EN) begin
            r_q <= bcd_inc(r_q);
        end
    end

    assign Q  = r_q;
    assign TC = (r_q == BCD_MAX);

endmodule

`default_nettype wire

// File: rtl/decade_chain_ctrl.sv
// ============================================================================
// Module   : decade_chain_ctrl
// Brief    : Run/pause/load sequencer, prescaler and ripple enables for a
//            cascade of BCD digits. DECADE_CHAIN_CMP_EN adds compare-and-pause.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decade_chain_ctrl
    import decade_chain_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int TICK_DIV = 10
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              START,
    input  logic              STOP,
    input  logic              LOAD_VALID,
    output logic              LOAD_READY,
    input  logic [3:0]        LOAD_DATA,
    output logic [NDIG-1:0]   DIG_EN,
    output logic [4*NDIG-1:0] CNT_Q,
    output logic              RUN,
    output logic              OVF
`ifdef DECADE_CHAIN_CMP_EN
    ,
    input  logic [4*NDIG-1:0] CMP_VAL,
    output logic              MATCH
`endif
);

    localparam int             c_PW    = $clog2(TICK_DIV + 1);
    localparam int             c_IW    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [c_PW-1:0] c_PMAX  = c_PW'(TICK_DIV - 1);
    localparam logic [c_IW-1:0] c_ILAST = c_IW'(NDIG - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_PW-1:0] r_presc;
    logic [c_IW-1:0] r_idx;
    logic            r_ready;
    logic            r_run;
    logic            r_ovf;
    logic            r_match;
    logic            w_tick;
    logic            w_accept;
    logic            w_last;
    logic            w_match;
    logic            w_all_nines;
    logic [NDIG-1:0] w_tc;
    logic [NDIG-1:0] w_dig_en;

    assign w_tick   = (r_state == ST_RUN) && (r_presc == c_PMAX);
    assign w_last   = (r_idx == c_ILAST);
    assign w_accept = LOAD_VALID && r_ready &&
                      (((r_state == ST_IDLE) && !START) || (r_state == ST_LOAD));

    // Ripple enable: digit k counts only when every lower digit sits at 9.
    always_comb begin
        w_all_nines = 1'b1;
        w_dig_en    = '0;
        for (int k = 0; k < NDIG; k++) begin
            w_dig_en[k] = w_tick & w_all_nines;
            w_all_nines = w_all_nines & w_tc[k];
        end
    end

`ifdef DECADE_CHAIN_CMP_EN
    logic [4*NDIG-1:0] w_cnt_nxt;

    // Compare against the value this tick produces, so the pause lands on the same edge.
    always_comb begin
        w_cnt_nxt = CNT_Q;
        for (int k = 0; k < NDIG; k++) begin
            if (w_dig_en[k]) begin
                w_cnt_nxt[4*k +: 4] = bcd_inc(CNT_Q[4*k +: 4]);
            end
        end
        w_match = w_tick && (w_cnt_nxt == CMP_VAL);
    end

    assign MATCH = r_match;
`else
    assign w_match = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_nxt = ST_RUN;
                end else if (w_accept) begin
                    w_state_nxt = w_last ? ST_IDLE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept && w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (STOP || w_match) begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (STOP) begin
                    w_state_nxt = ST_IDLE;
                end else if (START) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_run   <= 1'b0;
            r_ovf   <= 1'b0;
            r_match <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);
            r_run   <= (w_state_nxt == ST_RUN);
            r_ovf   <= w_tick & w_all_nines;
            r_match <= w_match;
            if (w_accept) begin
                r_idx <= w_last ? '0 : r_idx + c_IW'(1);
            end
            // A tick in flight always completes; STOP only freezes a partial period.
            if (r_state == ST_RUN) begin
                if (w_tick) begin
                    r_presc <= '0;
                end else if (!STOP) begin
                    r_presc <= r_presc + c_PW'(1);
                end
            end else if ((r_state == ST_PAUSE) && STOP) begin
                r_presc <= '0;
            end
        end
    end

    generate
        for (genvar k = 0; k < NDIG; k++) begin : g_digit
            bcd_digit u_digit (
                .CLK    (CLK),
                .CLR    (CLR),
                .EN     (w_dig_en[k]),
                .LD     (w_accept && (r_idx == c_IW'(k))),
                .LD_VAL (LOAD_DATA),
                .Q      (CNT_Q[4*k +: 4]),
                .TC     (w_tc[k])
            );
        end
    endgenerate

    assign DIG_EN     = w_dig_en;
    assign LOAD_READY = r_ready;
    assign RUN        = r_run;
    assign OVF        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_decade_chain_ctrl.sv
// ============================================================================
// Module   : tb_decade_chain_ctrl
// Brief    : Directed self-checking bench; u_dut uses TICK_DIV=3, u_dut1 TICK_DIV=1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decade_chain_ctrl;

    logic        CLK;
    logic        CLR, START, STOP, LOAD_VALID;
    logic [3:0]  LOAD_DATA;
    logic        LOAD_READY, RUN, OVF;
    logic [3:0]  DIG_EN;
    logic [15:0] CNT_Q;

    logic        b_CLR, b_START, b_STOP, b_LOAD_VALID;
    logic [3:0]  b_LOAD_DATA;
    logic        b_LOAD_READY, b_RUN, b_OVF;
    logic [3:0]  b_DIG_EN;
    logic [15:0] b_CNT_Q;

`ifdef DECADE_CHAIN_CMP_EN
    logic [15:0] CMP_VAL, b_CMP_VAL;
    logic        MATCH, b_MATCH;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    decade_chain_ctrl #(.NDIG(4), .TICK_DIV(3)) u_dut (
        .CLK(CLK), .CLR(CLR), .START(START), .STOP(STOP),
        .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY), .LOAD_DATA(LOAD_DATA),
        .DIG_EN(DIG_EN), .CNT_Q(CNT_Q), .RUN(RUN), .OVF(OVF)
`ifdef DECADE_CHAIN_CMP_EN
        , .CMP_VAL(CMP_VAL), .MATCH(MATCH)
`endif
    );

    decade_chain_ctrl #(.NDIG(4), .TICK_DIV(1)) u_dut1 (
        .CLK(CLK), .CLR(b_CLR), .START(b_START), .STOP(b_STOP),
        .LOAD_VALID(b_LOAD_VALID), .LOAD_READY(b_LOAD_READY), .LOAD_DATA(b_LOAD_DATA),
        .DIG_EN(b_DIG_EN), .CNT_Q(b_CNT_Q), .RUN(b_RUN), .OVF(b_OVF)
`ifdef DECADE_CHAIN_CMP_EN
        , .CMP_VAL(b_CMP_VAL), .MATCH(b_MATCH)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic load_digit(input logic [3:0] d);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = d;
        step(1);
        LOAD_VALID = 1'b0;
    endtask

    task automatic test_reset;
        CLR = 1'b1; b_CLR = 1'b1;
        step(2);
        n_tests++;
        if ({CNT_Q, RUN, OVF, LOAD_READY} !== {16'h0000, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_hold cnt/run/ovf/rdy=%h/%b/%b/%b exp 0000/0/0/0", CNT_Q, RUN, OVF, LOAD_READY);
        end
        CLR = 1'b0; b_CLR = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            n_tests++;
            if ({CNT_Q, RUN, OVF, LOAD_READY} !== {16'h0000, 3'b001}) begin
                n_fail++;
                $display("FAIL reset_idle[%0d] cnt/run/ovf/rdy=%h/%b/%b/%b exp 0000/0/0/1", i, CNT_Q, RUN, OVF, LOAD_READY);
            end
        end
    endtask

    task automatic test_load_count;
        load_digit(4'd4); load_digit(4'd5); load_digit(4'd9); load_digit(4'd12);
        n_tests++;
        if ({CNT_Q, LOAD_READY} !== {16'h0954, 1'b1}) begin
            n_fail++;
            $display("FAIL preset cnt/rdy=%h/%b exp 0954/1", CNT_Q, LOAD_READY);
        end
        START = 1'b1; step(1); START = 1'b0;
        n_tests++;
        if ({CNT_Q, RUN, LOAD_READY} !== {16'h0954, 2'b10}) begin
            n_fail++;
            $display("FAIL start cnt/run/rdy=%h/%b/%b exp 0954/1/0", CNT_Q, RUN, LOAD_READY);
        end
        step(2);
        n_tests++;
        if ({CNT_Q, DIG_EN} !== {16'h0954, 4'b0001}) begin
            n_fail++;
            $display("FAIL first_tick cnt/en=%h/%b exp 0954/0001", CNT_Q, DIG_EN);
        end
        step(1);
        n_tests++;
        if (CNT_Q !== 16'h0955) begin
            n_fail++;
            $display("FAIL count_3 cnt=%h exp 0955", CNT_Q);
        end
        step(9);
        n_tests++;
        if (CNT_Q !== 16'h0958) begin
            n_fail++;
            $display("FAIL count_12 cnt=%h exp 0958", CNT_Q);
        end
        step(3);
        n_tests++;
        if (CNT_Q !== 16'h0959) begin
            n_fail++;
            $display("FAIL count_15 cnt=%h exp 0959", CNT_Q);
        end
        step(2);
        n_tests++;
        if (DIG_EN !== 4'b0011) begin
            n_fail++;
            $display("FAIL ripple_en en=%b exp 0011", DIG_EN);
        end
        step(1);
        n_tests++;
        if ({CNT_Q, OVF} !== {16'h0960, 1'b0}) begin
            n_fail++;
            $display("FAIL carry cnt/ovf=%h/%b exp 0960/0", CNT_Q, OVF);
        end
        STOP = 1'b1; step(2); STOP = 1'b0;
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 4; i++) load_digit(4'd9);
        START = 1'b1; step(1); START = 1'b0;
        step(2);
        n_tests++;
        if ({CNT_Q, DIG_EN, OVF} !== {16'h9999, 4'b1111, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_tick cnt/en/ovf=%h/%b/%b exp 9999/1111/0", CNT_Q, DIG_EN, OVF);
        end
        step(1);
        n_tests++;
        if ({CNT_Q, OVF} !== {16'h0000, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap cnt/ovf=%h/%b exp 0000/1", CNT_Q, OVF);
        end
        step(1);
        n_tests++;
        if ({CNT_Q, OVF} !== {16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_pulse cnt/ovf=%h/%b exp 0000/0", CNT_Q, OVF);
        end
        STOP = 1'b1; step(2); STOP = 1'b0;
    endtask

    task automatic test_pause;
        START = 1'b1; step(1); START = 1'b0;
        step(1);
        STOP = 1'b1; step(1); STOP = 1'b0;
        step(4);
        n_tests++;
        if ({CNT_Q, RUN} !== {16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL paused cnt/run=%h/%b exp 0000/0", CNT_Q, RUN);
        end
        START = 1'b1; step(1); START = 1'b0;
        step(1);
        n_tests++;
        if ({CNT_Q, RUN, DIG_EN} !== {16'h0000, 1'b1, 4'b0001}) begin
            n_fail++;
            $display("FAIL resume cnt/run/en=%h/%b/%b exp 0000/1/0001", CNT_Q, RUN, DIG_EN);
        end
        step(1);
        n_tests++;
        if (CNT_Q !== 16'h0001) begin
            n_fail++;
            $display("FAIL resume_inc cnt=%h exp 0001", CNT_Q);
        end
        step(1);
        STOP = 1'b1; step(2); STOP = 1'b0;
        n_tests++;
        if ({CNT_Q, RUN, LOAD_READY} !== {16'h0001, 2'b01}) begin
            n_fail++;
            $display("FAIL stop_idle cnt/run/rdy=%h/%b/%b exp 0001/0/1", CNT_Q, RUN, LOAD_READY);
        end
        START = 1'b1; step(1); START = 1'b0;
        step(2);
        n_tests++;
        if (CNT_Q !== 16'h0001) begin
            n_fail++;
            $display("FAIL presc_reset_early cnt=%h exp 0001", CNT_Q);
        end
        step(1);
        n_tests++;
        if (CNT_Q !== 16'h0002) begin
            n_fail++;
            $display("FAIL presc_reset_inc cnt=%h exp 0002", CNT_Q);
        end
    endtask

    task automatic test_start_stop_clr;
        START = 1'b1; STOP = 1'b1; step(1); START = 1'b0; STOP = 1'b0;
        step(3);
        n_tests++;
        if ({CNT_Q, RUN} !== {16'h0002, 1'b0}) begin
            n_fail++;
            $display("FAIL start_stop cnt/run=%h/%b exp 0002/0", CNT_Q, RUN);
        end
        STOP = 1'b1; step(1); STOP = 1'b0;
        load_digit(4'd3); load_digit(4'd7);
        n_tests++;
        if ({CNT_Q, LOAD_READY} !== {16'h0073, 1'b1}) begin
            n_fail++;
            $display("FAIL partial_load cnt/rdy=%h/%b exp 0073/1", CNT_Q, LOAD_READY);
        end
        CLR = 1'b1; step(1); CLR = 1'b0;
        n_tests++;
        if ({CNT_Q, LOAD_READY} !== {16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL clr_mid_load cnt/rdy=%h/%b exp 0000/0", CNT_Q, LOAD_READY);
        end
        step(1);
        load_digit(4'd1); load_digit(4'd2); load_digit(4'd3); load_digit(4'd4);
        n_tests++;
        if ({CNT_Q, RUN, LOAD_READY} !== {16'h4321, 2'b01}) begin
            n_fail++;
            $display("FAIL reload cnt/run/rdy=%h/%b/%b exp 4321/0/1", CNT_Q, RUN, LOAD_READY);
        end
    endtask

    task automatic test_compare;
        b_START = 1'b1; step(1); b_START = 1'b0;
`ifdef DECADE_CHAIN_CMP_EN
        step(7);
        n_tests++;
        if ({b_CNT_Q, b_MATCH, b_RUN} !== {16'h0007, 2'b10}) begin
            n_fail++;
            $display("FAIL match cnt/match/run=%h/%b/%b exp 0007/1/0", b_CNT_Q, b_MATCH, b_RUN);
        end
        step(1);
        n_tests++;
        if ({b_CNT_Q, b_MATCH, b_RUN} !== {16'h0007, 2'b00}) begin
            n_fail++;
            $display("FAIL match_hold cnt/match/run=%h/%b/%b exp 0007/0/0", b_CNT_Q, b_MATCH, b_RUN);
        end
        n_tests++;
        if (MATCH !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_cmp match=%b exp 0", MATCH);
        end
`else
        step(9);
        n_tests++;
        if ({b_CNT_Q, b_DIG_EN} !== {16'h0009, 4'b0011}) begin
            n_fail++;
            $display("FAIL free_run9 cnt/en=%h/%b exp 0009/0011", b_CNT_Q, b_DIG_EN);
        end
        step(1);
        n_tests++;
        if ({b_CNT_Q, b_RUN} !== {16'h0010, 1'b1}) begin
            n_fail++;
            $display("FAIL free_run10 cnt/run=%h/%b exp 0010/1", b_CNT_Q, b_RUN);
        end
`endif
    endtask

    initial begin
        CLR = 1'b0; START = 1'b0; STOP = 1'b0; LOAD_VALID = 1'b0; LOAD_DATA = 4'd0;
        b_CLR = 1'b0; b_START = 1'b0; b_STOP = 1'b0; b_LOAD_VALID = 1'b0; b_LOAD_DATA = 4'd0;
`ifdef DECADE_CHAIN_CMP_EN
        CMP_VAL   = 16'hFFFF;
        b_CMP_VAL = 16'h0007;
`endif
        test_reset;
        test_load_count;
        test_wrap;
        test_pause;
        test_start_stop_clr;
        test_compare;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
